// File: rtl/lsu_master.sv
// Load/store initiator: one byte/half/word request at a time, sub-word stores done as read-modify-write.
// Latency: fault 1, load 2, word store 2, sub-word store 3 cycles from accept to resp_valid_o; no response backpressure.
module lsu_master #(
   parameter int unsigned MEM_WORDS = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_fault_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q;
   logic        we_q, uns_q;
   logic [1:0]  size_q, lane_q;
   logic [15:0] wdata_q;
   logic        resp_valid_q, resp_fault_q, mem_read_q, mem_write_q;
   logic [31:0] resp_rdata_q, mem_addr_q, mem_wdata_q;

   logic        fault_d;
   logic [31:0] load_d, merge_d;
   logic [7:0]  byte_d;
   logic [15:0] half_d;

   always_comb begin
      fault_d = (req_size_i == 2'b11)
             || (req_size_i == 2'b01 && req_addr_i[0])
             || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00)
             || ({2'b00, req_addr_i[31:2]} >= MEM_WORDS);

      byte_d = mem_rdata_i[{lane_q, 3'b000} +: 8];
      half_d = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   load_d = uns_q ? {24'h0, byte_d} : {{24{byte_d[7]}}, byte_d};
         2'b01:   load_d = uns_q ? {16'h0, half_d} : {{16{half_d[15]}}, half_d};
         default: load_d = mem_rdata_i;
      endcase

      // Old word with only the addressed lane replaced, written back in WR.
      merge_d = mem_rdata_i;
      if (size_q == 2'b00)
         merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else if (size_q == 2'b01)
         merge_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         size_q       <= 2'b00;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
      end else begin
         case (state_q)
            IDLE: if (req_valid_i) begin
               we_q    <= req_we_i;
               uns_q   <= req_unsigned_i;
               size_q  <= req_size_i;
               lane_q  <= req_addr_i[1:0];
               wdata_q <= req_wdata_i[15:0];
               if (fault_d) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_fault_q <= 1'b1;
                  resp_rdata_q <= 32'h0;
               end else if (req_we_i && req_size_i == 2'b10) begin
                  state_q     <= WR;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= {2'b00, req_addr_i[31:2]};
                  mem_wdata_q <= req_wdata_i;
               end else begin
                  state_q    <= RD;
                  mem_read_q <= 1'b1;
                  mem_addr_q <= {2'b00, req_addr_i[31:2]};
               end
            end
            RD: begin
               mem_read_q <= 1'b0;
               if (we_q) begin
                  state_q     <= WR;
                  mem_write_q <= 1'b1;
                  mem_wdata_q <= merge_d;
               end else begin
                  state_q      <= RESP;
                  mem_addr_q   <= 32'h0;
                  resp_valid_q <= 1'b1;
                  resp_fault_q <= 1'b0;
                  resp_rdata_q <= load_d;
               end
            end
            WR: begin
               state_q      <= RESP;
               mem_write_q  <= 1'b0;
               mem_addr_q   <= 32'h0;
               mem_wdata_q  <= 32'h0;
               resp_valid_q <= 1'b1;
               resp_fault_q <= 1'b0;
               resp_rdata_q <= 32'h0;
            end
            default: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               resp_fault_q <= 1'b0;
               resp_rdata_q <= 32'h0;
            end
         endcase
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_fault_o = resp_fault_q;
   assign mem_read_o   = mem_read_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Scoreboarded bench for lsu_master: directed cases, randomized traffic, reset during a store.
module tb_lsu_master;

   localparam int unsigned MEM_WORDS = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready, resp_valid, resp_fault, mem_read, mem_write;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

   lsu_master #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault),
      .mem_read_o(mem_read), .mem_write_o(mem_write),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   // Attached data memory: combinational read, commit on falling edge.
   logic [31:0] dmem [MEM_WORDS];
   assign mem_rdata = (mem_read && mem_addr < MEM_WORDS) ? dmem[mem_addr[4:0]] : 32'h0;
   always @(negedge clk)
      if (mem_write && mem_addr < MEM_WORDS) dmem[mem_addr[4:0]] <= mem_wdata;

   typedef struct {
      logic [31:0] rdata;
      bit          fault;
      int          lat, rd, wr, acc;
      logic [31:0] idx, wword;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [MEM_WORDS];
   int          vectors = 0, miscompares = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference behaviour from the access rules, updating the shadow memory on stores.
   function automatic exp_t model(bit we, logic [1:0] size, bit uns, logic [31:0] addr, logic [31:0] wdata);
      exp_t        e;
      logic [31:0] word, v, mask;
      int unsigned a, sh, width;
      a = addr;
      e = '{rdata: 32'h0, fault: 1'b0, lat: 0, rd: 0, wr: 0, acc: 0, idx: 32'h0, wword: 32'h0};
      e.fault = (size == 3) || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0)
             || (a / 4 >= MEM_WORDS);
      if (e.fault) begin
         e.lat = 1;
         return e;
      end
      e.idx = a / 4;
      word  = ref_mem[a / 4];
      if (!we) begin
         e.lat = 2; e.rd = 1;
         if (size == 0) begin
            v = (word >> (8 * (a % 4))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
         end else if (size == 1) begin
            v = (word >> (16 * ((a / 2) % 2))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
         end else v = word;
         e.rdata = v;
      end else begin
         if (size == 2) begin
            e.lat = 2; e.wr = 1; v = wdata;
         end else begin
            e.lat = 3; e.rd = 1; e.wr = 1;
            width = (size == 0) ? 8 : 16;
            sh    = (size == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
            mask  = ((32'd1 << width) - 1) << sh;
            v     = (word & ~mask) | ((wdata & ((32'd1 << width) - 1)) << sh);
         end
         ref_mem[a / 4] = v;
         e.wword = v;
      end
      return e;
   endfunction

   // Monitor: protocol checks every cycle, scoreboard pop on each response.
   always @(negedge clk) begin
      if (!rst_n) begin
         rd_cnt = 0; wr_cnt = 0;
      end else if (mon_en) begin
         chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
         chk("ready_low_when_busy", 32'(req_ready & (mem_read | mem_write | resp_valid)), 32'h0);
         if (mem_read || mem_write) begin
            if (sb.size() == 0) chk("mem_access_unexpected", 32'h1, 32'h0);
            else begin
               chk("mem_addr", mem_addr, sb[0].idx);
               if (mem_write) chk("mem_wdata", mem_wdata, sb[0].wword);
            end
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
         end else begin
            chk("mem_addr_idle", mem_addr, 32'h0);
            chk("mem_wdata_idle", mem_wdata, 32'h0);
         end
         if (resp_valid) begin
            if (sb.size() == 0) chk("resp_unexpected", 32'h1, 32'h0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_fault", 32'(resp_fault), 32'(e.fault));
               chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
               chk("read_cycles", 32'(rd_cnt), 32'(e.rd));
               chk("write_cycles", 32'(wr_cnt), 32'(e.wr));
            end
            rd_cnt = 0; wr_cnt = 0;
         end
      end
   end

   task automatic junk();
      req_valid    = 1'b1;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
   endtask

   // Presents a request that will be taken on the next rising edge.
   task automatic issue_now(bit we, logic [1:0] size, bit uns, logic [31:0] addr, logic [31:0] wdata, bit hold);
      exp_t e;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      e = model(we, size, uns, addr, wdata);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      if (hold) junk(); else req_valid = 1'b0;
   endtask

   task automatic do_req(bit we, logic [1:0] size, bit uns, logic [31:0] addr, logic [31:0] wdata, bit hold);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 100) begin
         if (hold) junk();
         guard++;
         @(negedge clk);
      end
      if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
      else issue_now(we, size, uns, addr, wdata, hold);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_pending", 32'(sb.size()), 32'h0);
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_resp_fault"}, 32'(resp_fault), 32'h0);
      chk({tag, "_mem_read"}, 32'(mem_read), 32'h0);
      chk({tag, "_mem_write"}, 32'(mem_write), 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
   endtask

   initial begin
      logic [31:0] old0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         dmem[i]    = $urandom;
         ref_mem[i] = dmem[i];
      end
      #3;
      chk_reset_outputs("reset");
      @(negedge clk); @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Word store/load, extension cases, sub-word read-modify-write
      do_req(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0);
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
      do_req(1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 0);
      do_req(0, 2'b00, 0, 32'h13, 32'h0, 0);
      do_req(0, 2'b00, 1, 32'h13, 32'h0, 0);
      do_req(0, 2'b00, 0, 32'h11, 32'h0, 0);
      do_req(0, 2'b01, 0, 32'h12, 32'h0, 0);
      do_req(1, 2'b10, 0, 32'h10, 32'h1122_3344, 0);
      do_req(1, 2'b00, 0, 32'h11, 32'h5555_55AA, 0);
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
      do_req(1, 2'b01, 0, 32'h12, 32'h1234_BEEF, 0);
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
      // Faults
      do_req(0, 2'b01, 0, 32'h01, 32'h0, 0);
      do_req(1, 2'b10, 0, 32'h06, 32'h1, 0);
      do_req(0, 2'b11, 0, 32'h08, 32'h0, 0);
      do_req(0, 2'b10, 0, 32'h80, 32'h0, 0);
      // Valid held high with changing fields between accepted requests
      for (int i = 0; i < 12; i++)
         do_req(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                32'($urandom_range(0, 32'h7F)), $urandom, 1);
      req_valid = 1'b0;
      // Random traffic including out-of-range and illegal sizes
      for (int i = 0; i < 300; i++)
         do_req(1'($urandom), 2'($urandom), 1'($urandom),
                32'($urandom_range(0, 32'h9F)), $urandom, 1'($urandom_range(0, 3) == 0));
      req_valid = 1'b0;
      drain();

      // Reset while a word store sits in WR, before the falling edge
      mon_en = 1'b0;
      old0   = ref_mem[0];
      @(negedge clk);
      chk("ready_before_rst", 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("wr_before_rst", 32'(mem_write), 32'h1);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("rst_in_wr");
      @(negedge clk); #1;
      chk("word0_kept", dmem[0], old0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      // First acceptance on the first rising edge after release
      issue_now(0, 2'b10, 0, 32'h0, 32'h0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
